memory_access: RTL and testbench
================================

# memory_access

Pipeline stage after `execute` in the RISC-V core. Consumes the execute stage's output bundle (result, rs2 value, read/write status, load-unsigned flag, destination register, write-back type, pc) and performs the data-memory access it describes. Drives a single-outstanding request/ready data-memory port, stalls upstream while an access is pending, and aligns and extends load data. Emits a registered bundle to the write-back stage.

## Interface
- Parameters: none; all widths fixed at 32-bit data/address.
- `clk` input 1: single clock, all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `valid_input` input 1: execute bundle valid this cycle.
- `result` input 32: ALU result; the byte address for memory ops.
- `rs2_value` input 32: store data.
- `read_status` input 2: 00 none, 01 byte, 10 half, 11 word load.
- `write_status` input 2: same encoding for stores.
- `load_unsigned` input 1: zero-extend loads when 1, sign-extend when 0.
- `destination_register_number` input 5: rd.
- `write_back_type` input 2: 00 none, 01 result, 10 load data, 11 pc+4.
- `pc` input 32: instruction pc.
- `stall` output 1: upstream holds its bundle while high.
- `mem_request` output 1: access pending.
- `mem_write` output 1: 1 store, 0 load.
- `mem_address` output 32: word address, `{result[31:2],2'b00}`.
- `mem_byte_enable` output 4: lane enables.
- `mem_write_data` output 32: lane-replicated store data.
- `mem_read_data` input 32: load data, valid when `mem_ready` is high.
- `mem_ready` input 1: access completes this cycle.
- `valid_output` output 1: write-back bundle valid.
- `writeback_value` output 32.
- `destination_register_number_output` output 5.
- `write_back_type_output` output 2.
- `pc_output` output 32.
- `access_fault` output 1: one-cycle pulse for a misaligned or illegal access.

## Operation
- FSM states are IDLE and WAIT. `stall` = (state == WAIT).
- A bundle is accepted at a posedge where `valid_input` is high and the state is IDLE. No bundle is accepted in WAIT.
- Non-memory bundle (both status fields 00):
  - `valid_output` is 1 next cycle.
  - `writeback_value` is `result` for type 01, `pc+4` (mod 2^32) for type 11, and 0 otherwise.
  - The state stays IDLE.
- Fault conditions:
  - Half access with `result[0]`=1.
  - Word access with `result[1:0]`≠0.
  - Both status fields nonzero.
- On a fault: no request is issued. Next cycle `access_fault`=1, `valid_output`=1, `write_back_type_output`=00, and the state stays IDLE.
- Legal memory bundle: capture address, enables, data, size, `load_unsigned`, rd, type and pc, then go to WAIT.
- Store lanes:
  - Byte: data `{4{rs2[7:0]}}`, enable `4'b0001<<result[1:0]`.
  - Half: data `{2{rs2[15:0]}}`, enable `result[1] ? 1100 : 0011`.
  - Word: data `rs2`, enable `1111`.
- Loads drive enable 1111 and write data 0.
- WAIT behaviour:
  - `mem_request`=1 and all `mem_*` outputs are held stable until `mem_ready` is sampled high.
  - On that posedge: state returns to IDLE, `valid_output`=1, and the bundle is emitted.
  - For loads, `writeback_value` = the selected lane (`mem_read_data >> 8*addr[1:0]`) truncated to the size, then sign- or zero-extended.
  - For stores, `writeback_value` = 0.
- Every cycle with no emission: `valid_output`=0 and `access_fault`=0. The other outputs hold their last values.

## Timing
- Reset values: state IDLE, `stall` 0, `mem_request` 0, `mem_write` 0, `mem_address` 0, `mem_byte_enable` 0, `mem_write_data` 0, `valid_output` 0, `writeback_value` 0, `destination_register_number_output` 0, `write_back_type_output` 0, `pc_output` 0, `access_fault` 0.
- Latency:
  - Non-memory or faulting bundle: 1 cycle.
  - Memory op: `mem_request` rises in cycle N+1 after acceptance at edge N. With `mem_ready` high in cycle N+1+k, the output is valid in cycle N+2+k. Minimum latency is 2 cycles.
- Throughput: a memory op occupies the stage for k+2 cycles. Back-to-back bundles resume the cycle after `stall` falls.
- `mem_ready` sampled while in IDLE is ignored.
- Reset asserted in WAIT: the request drops at the next edge, the pending access is abandoned, and no `valid_output` is produced.
- `valid_input` asserted while in WAIT is ignored; upstream must hold the bundle.

## Test plan
- ALU pass-through: `result`=0x0000_1234, type 01, rd 5 -> next cycle `valid_output`=1, `writeback_value`=0x1234, rd 5; `stall` stays 0.
- Signed byte load: addr 0x103, `mem_read_data`=0x80FF_0000, `mem_ready` after 3 wait cycles -> `mem_address`=0x100, `stall` high 4 cycles, `writeback_value`=0xFFFF_FF80. Repeat with `load_unsigned` -> 0x0000_0080.
- Half store: addr 0x22, `rs2`=0xABCD_1234 -> `mem_write`=1, enable 1100, data 0x1234_1234, address 0x20, all held until `mem_ready`.
- Misaligned word load at 0x41 -> no `mem_request`, next cycle `access_fault`=1, `valid_output`=1, type 00.
- Link: type 11, pc 0xFFFF_FFFC -> `writeback_value`=0x0000_0000.
- Reset in WAIT: assert `reset` during cycle 2 of a pending load -> `mem_request`=0 and `stall`=0 next cycle, no `valid_output`; a subsequent bundle is accepted normally.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access stage: turns an execute bundle into at most one data-memory
// request, waits for the memory to answer, then hands a registered bundle to
// write-back. Loads are lane-aligned and sign/zero-extended here.
module memory_access (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_input,
   input  logic [31:0] result,
   input  logic [31:0] rs2_value,
   input  logic [1:0]  read_status,
   input  logic [1:0]  write_status,
   input  logic        load_unsigned,
   input  logic [4:0]  destination_register_number,
   input  logic [1:0]  write_back_type,
   input  logic [31:0] pc,
   output logic        stall,
   output logic        mem_request,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   input  logic        mem_ready,
   output logic        valid_output,
   output logic [31:0] writeback_value,
   output logic [4:0]  destination_register_number_output,
   output logic [1:0]  write_back_type_output,
   output logic [31:0] pc_output,
   output logic        access_fault
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state;

   // Pending-access context kept for the response cycle
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [1:0]  offset_q;
   logic [4:0]  rd_q;
   logic [1:0]  wbt_q;
   logic [31:0] pc_q;

   logic [1:0]  access_size;
   logic        is_mem;
   logic        fault;
   logic [3:0]  store_be;
   logic [31:0] store_data;
   logic [31:0] lane;
   logic [31:0] load_value;
   logic [31:0] alu_value;

   assign stall = (state == WAIT);

   // Classify the incoming bundle: memory or not, and whether it must fault
   always_comb begin
      access_size = (read_status != 2'b00) ? read_status : write_status;
      is_mem      = (read_status != 2'b00) || (write_status != 2'b00);
      fault       = ((read_status != 2'b00) && (write_status != 2'b00))
                 || ((access_size == 2'b10) && result[0])
                 || ((access_size == 2'b11) && (result[1:0] != 2'b00));
   end

   // Replicate store data across lanes and pick the lanes being written
   always_comb begin
      store_be   = 4'b0000;
      store_data = 32'h0;
      case (write_status)
         2'b01: begin
            store_be   = 4'b0001 << result[1:0];
            store_data = {4{rs2_value[7:0]}};
         end
         2'b10: begin
            store_be   = result[1] ? 4'b1100 : 4'b0011;
            store_data = {2{rs2_value[15:0]}};
         end
         2'b11: begin
            store_be   = 4'b1111;
            store_data = rs2_value;
         end
         default: ;
      endcase
   end

   // Shift the addressed lane down, then truncate and extend to 32 bits
   always_comb begin
      lane = mem_read_data >> {offset_q, 3'b000};
      case (size_q)
         2'b01:   load_value = unsigned_q ? {24'h0, lane[7:0]}
                                          : {{24{lane[7]}}, lane[7:0]};
         2'b10:   load_value = unsigned_q ? {16'h0, lane[15:0]}
                                          : {{16{lane[15]}}, lane[15:0]};
         default: load_value = lane;
      endcase
   end

   // Write-back value for bundles that never touch memory
   always_comb begin
      case (write_back_type)
         2'b01:   alu_value = result;
         2'b11:   alu_value = pc + 32'd4;
         default: alu_value = 32'h0;
      endcase
   end

   // Stage FSM: accept in IDLE, hold the request in WAIT until mem_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state                              <= IDLE;
         mem_request                        <= 1'b0;
         mem_write                          <= 1'b0;
         mem_address                        <= 32'h0;
         mem_byte_enable                    <= 4'h0;
         mem_write_data                     <= 32'h0;
         valid_output                       <= 1'b0;
         writeback_value                    <= 32'h0;
         destination_register_number_output <= 5'h0;
         write_back_type_output             <= 2'b00;
         pc_output                          <= 32'h0;
         access_fault                       <= 1'b0;
         size_q                             <= 2'b00;
         unsigned_q                         <= 1'b0;
         offset_q                           <= 2'b00;
         rd_q                               <= 5'h0;
         wbt_q                              <= 2'b00;
         pc_q                               <= 32'h0;
      end else begin
         valid_output <= 1'b0;
         access_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_input) begin
                  if (!is_mem) begin
                     valid_output                       <= 1'b1;
                     writeback_value                    <= alu_value;
                     destination_register_number_output <= destination_register_number;
                     write_back_type_output             <= write_back_type;
                     pc_output                          <= pc;
                  end else if (fault) begin
                     // Faulting access retires with no write-back
                     valid_output                       <= 1'b1;
                     access_fault                       <= 1'b1;
                     writeback_value                    <= 32'h0;
                     destination_register_number_output <= destination_register_number;
                     write_back_type_output             <= 2'b00;
                     pc_output                          <= pc;
                  end else begin
                     mem_request     <= 1'b1;
                     mem_write       <= (write_status != 2'b00);
                     mem_address     <= {result[31:2], 2'b00};
                     mem_byte_enable <= (write_status != 2'b00) ? store_be : 4'b1111;
                     mem_write_data  <= store_data;
                     size_q          <= access_size;
                     unsigned_q      <= load_unsigned;
                     offset_q        <= result[1:0];
                     rd_q            <= destination_register_number;
                     wbt_q           <= write_back_type;
                     pc_q            <= pc;
                     state           <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  mem_request                        <= 1'b0;
                  state                              <= IDLE;
                  valid_output                       <= 1'b1;
                  writeback_value                    <= mem_write ? 32'h0 : load_value;
                  destination_register_number_output <= rd_q;
                  write_back_type_output             <= wbt_q;
                  pc_output                          <= pc_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus a randomized run checked
// against a byte-addressed memory model and the stage's retirement rules.
module tb_memory_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_input;
   logic [31:0] result, rs2_value, pc;
   logic [1:0]  read_status, write_status, write_back_type;
   logic        load_unsigned;
   logic [4:0]  destination_register_number;
   logic        stall, mem_request, mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic [3:0]  mem_byte_enable;
   logic        mem_ready;
   logic        valid_output;
   logic [31:0] writeback_value, pc_output;
   logic [4:0]  destination_register_number_output;
   logic [1:0]  write_back_type_output;
   logic        access_fault;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:255];

   typedef struct {
      bit          done, req_seen, unstable, wr, fault;
      logic [31:0] addr, wdata, wb, pc;
      logic [3:0]  be;
      logic [4:0]  rd;
      logic [1:0]  wbt;
      int          stalls;
   } obs_t;

   memory_access dut (
      .clk(clk), .reset(reset), .valid_input(valid_input), .result(result),
      .rs2_value(rs2_value), .read_status(read_status), .write_status(write_status),
      .load_unsigned(load_unsigned),
      .destination_register_number(destination_register_number),
      .write_back_type(write_back_type), .pc(pc), .stall(stall),
      .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
      .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .mem_ready(mem_ready),
      .valid_output(valid_output), .writeback_value(writeback_value),
      .destination_register_number_output(destination_register_number_output),
      .write_back_type_output(write_back_type_output), .pc_output(pc_output),
      .access_fault(access_fault)
   );

   always #5 clk = ~clk;

   // Value a load of nb bytes at byte index idx should return
   function automatic logic [31:0] model_load(input logic [7:0] idx, input int nb, input logic lu);
      logic [31:0] v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem[8'(idx + 8'(i))]) << (8 * i));
      if (!lu && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      return v;
   endfunction

   // Drive one bundle (called on a negedge while the stage is idle), play the
   // memory side with a dly-cycle response, and report what the DUT did.
   task automatic run_bundle(input logic [31:0] r, input logic [31:0] d, input logic [1:0] rs,
                             input logic [1:0] ws, input logic lu, input logic [4:0] rd,
                             input logic [1:0] wbt, input logic [31:0] pcv, input int dly,
                             input bit hold, output obs_t o);
      int wcnt = 0;
      logic [7:0] a;
      o.done = 0; o.req_seen = 0; o.unstable = 0; o.wr = 0; o.fault = 0; o.stalls = 0;
      o.addr = '0; o.wdata = '0; o.wb = '0; o.pc = '0; o.be = '0; o.rd = '0; o.wbt = '0;
      valid_input = 1; result = r; rs2_value = d; read_status = rs; write_status = ws;
      load_unsigned = lu; destination_register_number = rd; write_back_type = wbt; pc = pcv;
      @(posedge clk); #1;
      valid_input = hold;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (valid_output) begin
            o.done = 1; o.wb = writeback_value; o.rd = destination_register_number_output;
            o.wbt = write_back_type_output; o.pc = pc_output; o.fault = access_fault;
            break;
         end
         if (stall) o.stalls++;
         if (mem_request) begin
            if (!o.req_seen) begin
               o.req_seen = 1; o.wr = mem_write; o.addr = mem_address;
               o.be = mem_byte_enable; o.wdata = mem_write_data;
            end else if (o.wr !== mem_write || o.addr !== mem_address ||
                         o.be !== mem_byte_enable || o.wdata !== mem_write_data) begin
               o.unstable = 1;
            end
            if (wcnt == dly) begin
               a = mem_address[7:0];
               mem_ready = 1;
               mem_read_data = {mem[8'(a+3)], mem[8'(a+2)], mem[8'(a+1)], mem[a]};
            end
            wcnt++;
         end
         @(posedge clk); #1;
         mem_ready = 0; mem_read_data = $urandom;
      end
      valid_input = 0;
   endtask

   task automatic test_reset;
      reset = 1; valid_input = 0; mem_ready = 0; mem_read_data = '0; result = '0;
      rs2_value = '0; read_status = 0; write_status = 0; load_unsigned = 0;
      destination_register_number = 0; write_back_type = 0; pc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if ({stall, mem_request, mem_write, valid_output, access_fault} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000", {stall, mem_request, mem_write, valid_output, access_fault}); end
      total++; if ({mem_address, mem_byte_enable, mem_write_data} !== 68'h0) begin
         bad++; $display("FAIL reset_mem got=%h/%h/%h exp=0", mem_address, mem_byte_enable, mem_write_data); end
      total++; if ({writeback_value, destination_register_number_output, write_back_type_output, pc_output} !== 71'h0) begin
         bad++; $display("FAIL reset_wb got=%h/%h/%h/%h exp=0", writeback_value, destination_register_number_output, write_back_type_output, pc_output); end
      reset = 0;
   endtask

   task automatic test_alu;
      obs_t o;
      run_bundle(32'h0000_1234, 32'h0, 2'b00, 2'b00, 0, 5'd5, 2'b01, 32'h400, 0, 0, o);
      total++; if (!o.done) begin bad++; $display("FAIL alu_valid got=0 exp=1"); end
      total++; if (o.wb !== 32'h1234) begin bad++; $display("FAIL alu_wb got=%h exp=00001234", o.wb); end
      total++; if (o.rd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d exp=5", o.rd); end
      total++; if (o.stalls != 0 || o.req_seen) begin bad++; $display("FAIL alu_stall got=%0d/%0d exp=0/0", o.stalls, o.req_seen); end
   endtask

   task automatic test_byte_load;
      obs_t o;
      mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h80;
      run_bundle(32'h0000_0103, 32'h0, 2'b01, 2'b00, 0, 5'd7, 2'b10, 32'h500, 3, 1, o);
      total++; if (o.addr !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h exp=00000100", o.addr); end
      total++; if (o.stalls != 4) begin bad++; $display("FAIL lb_stall got=%0d exp=4", o.stalls); end
      total++; if (o.wb !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffff80", o.wb); end
      run_bundle(32'h0000_0103, 32'h0, 2'b01, 2'b00, 1, 5'd7, 2'b10, 32'h504, 3, 0, o);
      total++; if (o.wb !== 32'h0000_0080) begin bad++; $display("FAIL lbu_unsigned got=%h exp=00000080", o.wb); end
      total++; if (o.rd !== 5'd7 || o.pc !== 32'h504) begin bad++; $display("FAIL lbu_ctx got=%0d/%h exp=7/00000504", o.rd, o.pc); end
   endtask

   task automatic test_half_store;
      obs_t o;
      run_bundle(32'h0000_0022, 32'hABCD_1234, 2'b00, 2'b10, 0, 5'd0, 2'b00, 32'h600, 2, 1, o);
      total++; if (!o.wr || o.be !== 4'b1100) begin bad++; $display("FAIL sh_ctrl got=%b/%b exp=1/1100", o.wr, o.be); end
      total++; if (o.wdata !== 32'h1234_1234) begin bad++; $display("FAIL sh_data got=%h exp=12341234", o.wdata); end
      total++; if (o.addr !== 32'h20) begin bad++; $display("FAIL sh_addr got=%h exp=00000020", o.addr); end
      total++; if (o.unstable) begin bad++; $display("FAIL sh_hold got=unstable exp=stable"); end
      total++; if (o.wb !== 32'h0) begin bad++; $display("FAIL sh_wb got=%h exp=00000000", o.wb); end
      mem[8'h22] = 8'h34; mem[8'h23] = 8'h12;
   endtask

   task automatic test_misaligned;
      obs_t o;
      run_bundle(32'h0000_0041, 32'h0, 2'b11, 2'b00, 0, 5'd3, 2'b10, 32'h700, 0, 0, o);
      total++; if (o.req_seen) begin bad++; $display("FAIL mis_req got=1 exp=0"); end
      total++; if (!o.done || !o.fault) begin bad++; $display("FAIL mis_fault got=%b/%b exp=1/1", o.done, o.fault); end
      total++; if (o.wbt !== 2'b00) begin bad++; $display("FAIL mis_type got=%b exp=00", o.wbt); end
      @(negedge clk);
      total++; if (access_fault || valid_output) begin bad++; $display("FAIL mis_pulse got=%b/%b exp=0/0", access_fault, valid_output); end
   endtask

   task automatic test_link;
      obs_t o;
      run_bundle(32'h1111_1111, 32'h0, 2'b00, 2'b00, 0, 5'd1, 2'b11, 32'hFFFF_FFFC, 0, 0, o);
      total++; if (!o.done || o.wb !== 32'h0) begin bad++; $display("FAIL link_wb got=%b/%h exp=1/00000000", o.done, o.wb); end
      total++; if (o.wbt !== 2'b11 || o.pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL link_ctx got=%b/%h exp=11/fffffffc", o.wbt, o.pc); end
   endtask

   task automatic test_ready_idle;
      bit seen = 0;
      mem_ready = 1;
      repeat (3) begin
         @(negedge clk);
         if (valid_output || mem_request || stall) seen = 1;
      end
      mem_ready = 0;
      total++; if (seen) begin bad++; $display("FAIL ready_idle got=activity exp=none"); end
   endtask

   task automatic test_reset_in_wait;
      obs_t o;
      bit vo = 0;
      valid_input = 1; result = 32'h80; rs2_value = 0; read_status = 2'b11; write_status = 0;
      load_unsigned = 0; destination_register_number = 5'd9; write_back_type = 2'b10; pc = 32'h800;
      @(posedge clk); #1; valid_input = 0;
      @(posedge clk); #1; reset = 1;
      @(posedge clk); #1; reset = 0;
      @(negedge clk);
      total++; if (mem_request || stall) begin bad++; $display("FAIL rst_wait got=%b/%b exp=0/0", mem_request, stall); end
      repeat (3) begin if (valid_output) vo = 1; @(negedge clk); end
      total++; if (vo) begin bad++; $display("FAIL rst_novalid got=1 exp=0"); end
      run_bundle(32'h0000_00AA, 32'h0, 2'b00, 2'b00, 0, 5'd4, 2'b01, 32'h900, 0, 0, o);
      total++; if (!o.done || o.wb !== 32'hAA) begin bad++; $display("FAIL rst_after got=%b/%h exp=1/000000aa", o.done, o.wb); end
   endtask

   task automatic test_random;
      obs_t o;
      for (int n = 0; n < 80; n++) begin
         logic [31:0] r, d, pcv, ew, ewd;
         logic [1:0] rs, ws, wbt, sz;
         logic lu;
         logic [4:0] rd;
         logic [3:0] ebe;
         bit flt, mem_op;
         int kind, nb, dly;
         rs = 0; ws = 0;
         kind = $urandom_range(0, 9);
         if (kind >= 2 && kind < 5) rs = 2'($urandom_range(1, 3));
         else if (kind >= 5 && kind < 8) ws = 2'($urandom_range(1, 3));
         else if (kind >= 8) begin rs = 2'($urandom_range(1, 3)); ws = 2'($urandom_range(1, 3)); end
         sz = (rs != 0) ? rs : ws;
         r = $urandom; d = $urandom; pcv = $urandom; lu = 1'($urandom);
         rd = 5'($urandom); wbt = 2'($urandom); dly = $urandom_range(0, 4);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2) r[0] = 0;
            if (sz == 3) r[1:0] = 0;
         end
         nb = (sz == 1) ? 1 : (sz == 2) ? 2 : 4;
         mem_op = (rs != 0) || (ws != 0);
         flt = (rs != 0 && ws != 0) || (sz == 2 && r[0]) || (sz == 3 && r[1:0] != 0);
         run_bundle(r, d, rs, ws, lu, rd, wbt, pcv, dly, 1'($urandom), o);
         total++; if (!o.done) begin bad++; $display("FAIL rnd%0d_timeout got=0 exp=1", n); end
         total++; if (o.fault !== flt) begin bad++; $display("FAIL rnd%0d_fault got=%b exp=%b", n, o.fault, flt); end
         total++; if (o.req_seen != (mem_op && !flt)) begin bad++; $display("FAIL rnd%0d_req got=%b exp=%b", n, o.req_seen, mem_op && !flt); end
         total++; if (o.rd !== rd || o.pc !== pcv) begin bad++; $display("FAIL rnd%0d_ctx got=%0d/%h exp=%0d/%h", n, o.rd, o.pc, rd, pcv); end
         if (!mem_op) begin
            ew = (wbt == 1) ? r : (wbt == 3) ? pcv + 32'd4 : 32'h0;
            total++; if (o.wb !== ew || o.wbt !== wbt) begin bad++; $display("FAIL rnd%0d_alu got=%h/%b exp=%h/%b", n, o.wb, o.wbt, ew, wbt); end
         end else if (flt) begin
            total++; if (o.wbt !== 2'b00) begin bad++; $display("FAIL rnd%0d_ftype got=%b exp=00", n, o.wbt); end
         end else begin
            ebe = (ws != 0) ? 4'(((1 << nb) - 1) << r[1:0]) : 4'hF;
            ewd = (ws == 0) ? 32'h0 : (nb == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                  (nb == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
            ew = (ws != 0) ? 32'h0 : model_load(r[7:0], nb, lu);
            total++; if (o.addr !== (r & 32'hFFFF_FFFC) || o.wr !== (ws != 0)) begin bad++; $display("FAIL rnd%0d_addr got=%h/%b exp=%h/%b", n, o.addr, o.wr, r & 32'hFFFF_FFFC, ws != 0); end
            total++; if (o.be !== ebe || o.wdata !== ewd) begin bad++; $display("FAIL rnd%0d_lanes got=%b/%h exp=%b/%h", n, o.be, o.wdata, ebe, ewd); end
            total++; if (o.stalls != dly + 1 || o.unstable) begin bad++; $display("FAIL rnd%0d_wait got=%0d/%b exp=%0d/0", n, o.stalls, o.unstable, dly + 1); end
            total++; if (o.wb !== ew || o.wbt !== wbt) begin bad++; $display("FAIL rnd%0d_wb got=%h/%b exp=%h/%b", n, o.wb, o.wbt, ew, wbt); end
            if (ws != 0) for (int i = 0; i < nb; i++) mem[8'(r[7:0] + 8'(i))] = 8'(d >> (8 * i));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      test_reset;
      @(negedge clk);
      test_alu;
      test_byte_load;
      test_half_store;
      test_misaligned;
      test_link;
      test_ready_idle;
      test_reset_in_wait;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
